// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: buffers renamed micro-ops, snoops the CDB,
// and issues the oldest ready entry into a registered slot. Optional macro: ALU_RS_WAKEUP_BYPASS_EN.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 7,
    parameter int ROB_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [4:0]       disp_opcode,
    input  logic [2:0]       disp_funct3,
    input  logic             disp_funct7,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [31:0]      disp_rs1_data,
    input  logic [31:0]      disp_rs2_data,
    input  logic [31:0]      disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [ROB_W-1:0] disp_rob_idx,
    input  logic [TAG_W-1:0] disp_rd,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             flush,
    output logic             alu_i_valid,
    output logic [4:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic [31:0]      alu_rs1_data,
    output logic [31:0]      alu_rs2_data,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_i_rob_idx,
    output logic [TAG_W-1:0] alu_i_rd
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid, rs1_rdy, rs2_rdy;
    logic [DEPTH-1:0] older [DEPTH];
    logic [4:0]       e_opcode [DEPTH];
    logic [2:0]       e_funct3 [DEPTH];
    logic [DEPTH-1:0] e_funct7;
    logic [TAG_W-1:0] e_rs1_tag [DEPTH];
    logic [TAG_W-1:0] e_rs2_tag [DEPTH];
    logic [31:0]      e_rs1_data [DEPTH];
    logic [31:0]      e_rs2_data [DEPTH];
    logic [31:0]      e_imm [DEPTH];
    logic [31:0]      e_pc [DEPTH];
    logic [ROB_W-1:0] e_rob [DEPTH];
    logic [TAG_W-1:0] e_rd [DEPTH];

    logic [DEPTH-1:0] rs1_wake, rs2_wake, ready, sel;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic [31:0]      sel_rs1_data, sel_rs2_data;
    logic             disp_fire, disp_rs1_hit, disp_rs2_hit;

    assign disp_ready   = ~&valid;
    assign disp_fire    = disp_valid && disp_ready && !flush;
    assign disp_rs1_hit = !disp_rs1_rdy && cdb_valid && (cdb_tag == disp_rs1_tag);
    assign disp_rs2_hit = !disp_rs2_rdy && cdb_valid && (cdb_tag == disp_rs2_tag);

    always_comb begin
        rs1_wake = '0;
        rs2_wake = '0;
        ready    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_wake[i] = valid[i] && !rs1_rdy[i] && cdb_valid && (cdb_tag == e_rs1_tag[i]);
            rs2_wake[i] = valid[i] && !rs2_rdy[i] && cdb_valid && (cdb_tag == e_rs2_tag[i]);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready[i] = valid[i] && (rs1_rdy[i] || rs1_wake[i]) && (rs2_rdy[i] || rs2_wake[i]);
`else
            ready[i] = valid[i] && rs1_rdy[i] && rs2_rdy[i];
`endif
        end
    end

    // older[j][i] set means entry j was dispatched before entry i
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older[j][i]) sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        sel_rs1_data = e_rs1_data[sel_idx];
        sel_rs2_data = e_rs2_data[sel_idx];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        if (!rs1_rdy[sel_idx]) sel_rs1_data = cdb_data;
        if (!rs2_rdy[sel_idx]) sel_rs2_data = cdb_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rs1_wake[i]) rs1_rdy[i] <= 1'b1;
                if (rs2_wake[i]) rs2_rdy[i] <= 1'b1;
            end
            if (sel_found) valid[sel_idx] <= 1'b0;
            if (disp_fire) begin
                valid[free_idx]   <= 1'b1;
                rs1_rdy[free_idx] <= disp_rs1_rdy || disp_rs1_hit;
                rs2_rdy[free_idx] <= disp_rs2_rdy || disp_rs2_hit;
            end
        end
    end

    // Payload and age storage need no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rs1_wake[i]) e_rs1_data[i] <= cdb_data;
                if (rs2_wake[i]) e_rs2_data[i] <= cdb_data;
            end
            if (disp_fire) begin
                e_opcode[free_idx]   <= disp_opcode;
                e_funct3[free_idx]   <= disp_funct3;
                e_funct7[free_idx]   <= disp_funct7;
                e_rs1_tag[free_idx]  <= disp_rs1_tag;
                e_rs2_tag[free_idx]  <= disp_rs2_tag;
                e_rs1_data[free_idx] <= disp_rs1_rdy ? disp_rs1_data : cdb_data;
                e_rs2_data[free_idx] <= disp_rs2_rdy ? disp_rs2_data : cdb_data;
                e_imm[free_idx]      <= disp_imm;
                e_pc[free_idx]       <= disp_pc;
                e_rob[free_idx]      <= disp_rob_idx;
                e_rd[free_idx]       <= disp_rd;
                for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= 1'b1;
                older[free_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_i_valid   <= 1'b0;
            alu_opcode    <= '0;
            alu_funct3    <= '0;
            alu_funct7    <= 1'b0;
            alu_rs1_data  <= '0;
            alu_rs2_data  <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_i_rob_idx <= '0;
            alu_i_rd      <= '0;
        end else if (flush) begin
            alu_i_valid <= 1'b0;
        end else begin
            alu_i_valid <= sel_found;
            if (sel_found) begin
                alu_opcode    <= e_opcode[sel_idx];
                alu_funct3    <= e_funct3[sel_idx];
                alu_funct7    <= e_funct7[sel_idx];
                alu_rs1_data  <= sel_rs1_data;
                alu_rs2_data  <= sel_rs2_data;
                alu_imm       <= e_imm[sel_idx];
                alu_pc        <= e_pc[sel_idx];
                alu_i_rob_idx <= e_rob[sel_idx];
                alu_i_rd      <= e_rd[sel_idx];
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard testbench for alu_rs; expected issue payloads are queued in predicted issue order.
module tb_alu_rs;
    localparam int TAG_W = 7;
    localparam int ROB_W = 3;
    localparam logic [4:0] R_TYPE = 5'b01100;

    typedef struct packed {
        logic [4:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] rd;
    } payload_t;

    logic clk = 1'b0;
    logic rst;
    logic disp_valid, disp_ready, disp_funct7, disp_rs1_rdy, disp_rs2_rdy;
    logic [4:0] disp_opcode;
    logic [2:0] disp_funct3;
    logic [TAG_W-1:0] disp_rs1_tag, disp_rs2_tag, disp_rd, cdb_tag;
    logic [31:0] disp_rs1_data, disp_rs2_data, disp_imm, disp_pc, cdb_data;
    logic [ROB_W-1:0] disp_rob_idx;
    logic cdb_valid, flush;
    logic alu_i_valid, alu_funct7;
    logic [4:0] alu_opcode;
    logic [2:0] alu_funct3;
    logic [31:0] alu_rs1_data, alu_rs2_data, alu_imm, alu_pc;
    logic [ROB_W-1:0] alu_i_rob_idx;
    logic [TAG_W-1:0] alu_i_rd;

    payload_t sb[$];
    payload_t observed, expPayload;
    int checkCount = 0;
    int passCount = 0;

    alu_rs #(.DEPTH(4), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
        .alu_i_valid(alu_i_valid), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_i_rob_idx(alu_i_rob_idx), .alu_i_rd(alu_i_rd)
    );

    always #5 clk = ~clk;

    always_comb observed = {alu_opcode, alu_funct3, alu_funct7, alu_rs1_data, alu_rs2_data,
                            alu_imm, alu_pc, alu_i_rob_idx, alu_i_rd};

    task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic payload_t makePayload(input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [31:0] pc, input logic [ROB_W-1:0] rob,
                                             input logic [TAG_W-1:0] rd);
        payload_t p;
        p.opcode = R_TYPE;
        p.funct3 = 3'b000;
        p.funct7 = rd[0];
        p.rs1    = rs1;
        p.rs2    = rs2;
        p.imm    = pc ^ 32'h0000_0F0F;
        p.pc     = pc;
        p.rob    = rob;
        p.rd     = rd;
        return p;
    endfunction

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one dispatch for a single edge, then drops dispatch, CDB and flush
    task automatic applyStimulus(input payload_t p, input logic r1rdy, input logic [TAG_W-1:0] t1,
                                 input logic r2rdy, input logic [TAG_W-1:0] t2, input bit push);
        disp_opcode   = p.opcode;
        disp_funct3   = p.funct3;
        disp_funct7   = p.funct7;
        disp_rs1_data = p.rs1;
        disp_rs2_data = p.rs2;
        disp_imm      = p.imm;
        disp_pc       = p.pc;
        disp_rob_idx  = p.rob;
        disp_rd       = p.rd;
        disp_rs1_rdy  = r1rdy;
        disp_rs1_tag  = t1;
        disp_rs2_rdy  = r2rdy;
        disp_rs2_tag  = t2;
        disp_valid    = 1'b1;
        if (push) sb.push_back(p);
        waitCycle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic cdbPulse(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        waitCycle();
        cdb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && alu_i_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected issue", 160'(alu_i_valid), 160'd0);
            end else begin
                expPayload = sb.pop_front();
                checkOutput("issue payload", 160'(observed), 160'(expPayload));
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        payload_t p, pw[4];
        rst = 1'b1; disp_valid = 1'b0; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        disp_opcode = '0; disp_funct3 = '0; disp_funct7 = 1'b0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_data = '0; disp_rs2_data = '0;
        disp_imm = '0; disp_pc = '0; disp_rob_idx = '0; disp_rd = '0;
        #12;
        checkOutput("reset valid", 160'(alu_i_valid), 160'd0);
        checkOutput("reset disp_ready", 160'(disp_ready), 160'd1);
        checkOutput("reset payload", 160'(observed), 160'd0);
        rst = 1'b0;
        waitCycle();

        // Basic ready dispatch
        applyStimulus(makePayload(32'd5, 32'd7, 32'h100, 3'd2, 7'd9), 1, 0, 1, 0, 1);
        checkOutput("t1 no early issue", 160'(alu_i_valid), 160'd0);
        waitCycle();
        checkOutput("t1 issue valid", 160'(alu_i_valid), 160'd1);
        checkOutput("t1 rob", 160'(alu_i_rob_idx), 160'd2);
        waitCycle();
        checkOutput("t1 idle after", 160'(alu_i_valid), 160'd0);

        // Younger ready op overtakes an older waiting one
        p = makePayload(32'h0, 32'h22, 32'h200, 3'd3, 7'd10);
        applyStimulus(p, 0, 7'd12, 1, 0, 0);
        applyStimulus(makePayload(32'd1, 32'd2, 32'h204, 3'd4, 7'd11), 1, 0, 1, 0, 1);
        waitCycle();
        checkOutput("t2 B first", 160'(alu_i_rd), 160'd11);
        waitCycle();
        checkOutput("t2 A waits", 160'(alu_i_valid), 160'd0);
        p.rs1 = 32'h100;
        sb.push_back(p);
        cdbPulse(7'd12, 32'h100);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        checkOutput("t2 A bypass issue", 160'(alu_i_valid), 160'd1);
`else
        checkOutput("t2 A not yet", 160'(alu_i_valid), 160'd0);
        waitCycle();
        checkOutput("t2 A issue", 160'(alu_i_valid), 160'd1);
`endif
        checkOutput("t2 A rd", 160'(alu_i_rd), 160'd10);
        waitCycle();

        // Fill, overflow attempt, then ordered drain
        for (int k = 0; k < 4; k++) begin
            pw[k] = makePayload(32'h0, 32'h40 + k, 32'h300 + 4 * k, 3'(k), 7'(20 + k));
            applyStimulus(pw[k], 0, 7'd3, 1, 0, 0);
        end
        checkOutput("t3 full", 160'(disp_ready), 160'd0);
        applyStimulus(makePayload(32'd9, 32'd9, 32'h3F0, 3'd7, 7'd30), 1, 0, 1, 0, 0);
        checkOutput("t3 still full", 160'(disp_ready), 160'd0);
        checkOutput("t3 nothing issued", 160'(alu_i_valid), 160'd0);
        for (int k = 0; k < 4; k++) begin
            pw[k].rs1 = 32'h333;
            sb.push_back(pw[k]);
        end
        cdbPulse(7'd3, 32'h333);
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        checkOutput("t3 full after wake", 160'(disp_ready), 160'd0);
        waitCycle();
`endif
        checkOutput("t3 first issue", 160'(alu_i_rd), 160'd20);
        checkOutput("t3 ready after issue", 160'(disp_ready), 160'd1);
        for (int c = 0; c < 10 && sb.size() != 0; c++) waitCycle();
        checkOutput("t3 drained", 160'(sb.size()), 160'd0);
        waitCycle();
        checkOutput("t3 idle", 160'(alu_i_valid), 160'd0);

        // Dispatch captures a same-cycle CDB broadcast
        p = makePayload(32'h11, 32'hDEAD, 32'h400, 3'd5, 7'd40);
        expPayload = p;
        expPayload.rs2 = 32'hABCD;
        sb.push_back(expPayload);
        cdb_valid = 1'b1; cdb_tag = 7'd20; cdb_data = 32'hABCD;
        applyStimulus(p, 1, 0, 0, 7'd20, 0);
        checkOutput("t4 not same cycle", 160'(alu_i_valid), 160'd0);
        waitCycle();
        checkOutput("t4 rs2 forwarded", 160'(alu_rs2_data), 160'h0000ABCD);
        waitCycle();

        // Flush with three ready entries and a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            pw[k] = makePayload(32'h0, 32'h50 + k, 32'h500 + 4 * k, 3'(k), 7'(50 + k));
            applyStimulus(pw[k], 0, 7'd41, 1, 0, 0);
        end
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        pw[0].rs1 = 32'h4141;
        sb.push_back(pw[0]);
`endif
        cdbPulse(7'd41, 32'h4141);
        flush = 1'b1;
        applyStimulus(makePayload(32'd3, 32'd4, 32'h5F0, 3'd6, 7'd59), 1, 0, 1, 0, 0);
        checkOutput("t5 flush valid", 160'(alu_i_valid), 160'd0);
        checkOutput("t5 flush ready", 160'(disp_ready), 160'd1);
        for (int c = 0; c < 4; c++) begin
            waitCycle();
            checkOutput("t5 quiet", 160'(alu_i_valid), 160'd0);
        end

        // Asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++)
            applyStimulus(makePayload(32'h60 + k, 32'h61, 32'h600 + 4 * k, 3'(k), 7'(60 + k)), 1, 0, 1, 0, k < 2);
        checkOutput("t6 issuing", 160'(alu_i_rd), 160'd61);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6 async valid", 160'(alu_i_valid), 160'd0);
        checkOutput("t6 async rd", 160'(alu_i_rd), 160'd0);
        checkOutput("t6 async ready", 160'(disp_ready), 160'd1);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            waitCycle();
            checkOutput("t6 quiet", 160'(alu_i_valid), 160'd0);
        end
        applyStimulus(makePayload(32'h77, 32'h88, 32'h700, 3'd1, 7'd70), 1, 0, 1, 0, 1);
        waitCycle();
        checkOutput("t6 post-reset issue", 160'(alu_i_rd), 160'd70);
        waitCycle();
        checkOutput("scoreboard empty", 160'(sb.size()), 160'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU.
- Accepts renamed ALU/branch/jump micro-ops from dispatch and buffers them until both source operands are available.
- Operand values arrive either at dispatch or by snooping the common data bus (CDB).
- Each cycle it selects the oldest ready entry and drives it into a registered issue slot that feeds the ALU's opcode/operand/control inputs.

Parameters:
- DEPTH, 4, number of RS entries (power of two, 2..8).
- TAG_W, 7, physical-register tag width; matches the ALU rd width.
- ROB_W, 3, ROB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- disp_valid  in  1  dispatch offers a micro-op.
- disp_ready  out  1  free entry available (count < DEPTH).
- disp_opcode  in  5  opcode[6:2].
- disp_funct3  in  3  funct3.
- disp_funct7  in  1  instr[30].
- disp_rs1_rdy / disp_rs2_rdy  in  1 each  operand already valid at dispatch.
- disp_rs1_tag / disp_rs2_tag  in  TAG_W each  producer tags.
- disp_rs1_data / disp_rs2_data  in  32 each  operand values (used when rdy=1).
- disp_imm  in  32  immediate.
- disp_pc  in  32  instruction PC.
- disp_rob_idx  in  ROB_W  ROB slot.
- disp_rd  in  TAG_W  destination tag.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- flush  in  1  pipeline flush (mispredict/jump redirect).
- alu_i_valid  out  1  issue slot valid.
- alu_opcode, alu_funct3, alu_funct7, alu_rs1_data, alu_rs2_data, alu_imm, alu_pc, alu_i_rob_idx, alu_i_rd  out  as dispatch widths  registered issue payload.

Behaviour:
- Reset (async, rst=1):
  - All entry valid bits cleared.
  - All alu_* outputs 0, alu_i_valid=0.
  - disp_ready=1 (combinational from the entry count).
- Dispatch:
  - Fires when disp_valid && disp_ready && !flush.
  - Writes the lowest-index free entry and stamps it younger than all occupied entries.
- CDB wakeup, per entry and source:
  - If the entry is valid, the source is not ready, and cdb_valid && cdb_tag==src_tag: capture cdb_data and set ready at the edge.
  - Applies identically to a micro-op dispatching the same cycle: if disp_rsX_rdy=0 and the tag matches the CDB, the entry is written already ready with cdb_data.
- Readiness: an entry is ready when valid && rs1_rdy && rs2_rdy. The slot stores both operands regardless of opcode; the ALU ignores unused ones.
- Select and issue:
  - Among ready entries (readiness evaluated from registered state, before this cycle's wakeup), pick the oldest by dispatch order.
  - At the edge, load its payload into the issue register, set alu_i_valid=1, and free the entry.
  - With no ready entry, alu_i_valid=0 next cycle; the payload holds its old value.
- Latency:
  - Dispatch with both operands ready at edge t → alu_i_valid at t+1 at the earliest.
  - CDB wakeup at edge t → issue register loaded at edge t+1.
- No backpressure from the ALU: the issue slot is consumed every cycle.
- Full:
  - disp_ready=0 when all DEPTH entries are valid. It does not look ahead to an entry being issued the same cycle.
  - disp_valid while !disp_ready is ignored with no state change.
- Simultaneous issue and dispatch: the issued entry is freed and the dispatched micro-op takes a different free entry in the same cycle. The just-freed slot is reusable next cycle.
- Flush:
  - At the edge, clear all entry valid bits and alu_i_valid.
  - Blocks dispatch, wakeup and issue that cycle.
  - Takes priority over all other events.
- Reset mid-operation drops all entries and the issue slot immediately, without waiting for a clock edge.
- Age ordering must stay correct across any free/refill pattern: a per-entry age matrix or ordinal counters, width clog2(DEPTH).

Optional Feature:
- Macro ALU_RS_WAKEUP_BYPASS_EN.
- When defined:
  - Readiness also counts sources matching this cycle's CDB broadcast.
  - Such an entry may issue at the same edge as its wakeup, with cdb_data forwarded into the issue register.
  - Wakeup-to-issue latency drops by one cycle.
  - A micro-op dispatching this cycle is never selected the same cycle.
- When undefined: behaviour exactly as above.

Test Plan:
- After reset: disp_valid with both rdy=1, opcode R_TYPE, funct3 ADD, rs1=5, rs2=7, rob_idx=2, rd=9 → alu_i_valid=1 next cycle with rs1_data=5, rs2_data=7, rob_idx=2, rd=9; then 0.
- Dispatch A (rs1 tag 12 not ready) then B (both ready) → B issues first. CDB tag 12 data 0x100 → A issues 2 cycles after the broadcast edge with rs1_data=0x100 (1 cycle with ALU_RS_WAKEUP_BYPASS_EN).
- Fill 4 entries all waiting on tag 3 → disp_ready=0 and a 5th dispatch is ignored. CDB tag 3 → entries issue one per cycle in dispatch order; disp_ready returns to 1 after the first issue.
- Same-cycle dispatch with rs2_rdy=0 and tag 20 while the CDB broadcasts tag 20 data 0xABCD → entry issues the next cycle with rs2_data=0xABCD.
- 3 valid ready entries plus flush and disp_valid in the same cycle → alu_i_valid=0 next cycle, no entries remain, the dispatched op is dropped, disp_ready=1.
- Assert rst asynchronously mid-cycle with entries valid → alu_i_valid drops to 0 before the next edge; no issues after release until new dispatch.
